uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync_fifo.sv | 66 ++++++
 rtl/uart_rx_fifo.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: parity encodings,
// receiver state type and helpers that derive counter widths from parameters.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // System clocks per oversampling tick.
    function automatic int calc_baud_dv(input int sys_freq, input int baud_rate, input int sample);
        return sys_freq / (sample * baud_rate);
    endfunction

    // Counter width able to hold values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small register-based receive FIFO. The head entry is shown combinationally
// so it is visible the cycle after a push into an empty FIFO; it reads 0 when empty.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = cnt_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote bit sampling, parity/framing
// checks, break handling and a receive FIFO with a sticky overrun flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int SYS_FREQ    = 50000000,
    parameter int BAUD_RATE   = 9600,
    parameter int SAMPLE      = 16,
    parameter int DATA_SIZE   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            rx,
    output logic [DATA_SIZE-1:0]            dout,
    output logic                            parity_err,
    output logic                            frame_err,
    output logic                            recv_req,
    input  logic                            recv_ack,
    output logic                            overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int   BAUD_DV    = calc_baud_dv(SYS_FREQ, BAUD_RATE, SAMPLE);
    localparam int   TICK_W     = cnt_width(BAUD_DV);
    localparam int   SAMP_W     = cnt_width(SAMPLE);
    localparam int   BIT_W      = cnt_width(DATA_SIZE);
    localparam int   ENTRY_W    = DATA_SIZE + 2;
    localparam logic PAR_TARGET = (PARITY_MODE == PARITY_EVEN) ? 1'b0 : 1'b1;

    logic              r_rx_meta;
    logic              r_rx_sync;
    logic              r_rx_prev;
    logic [1:0]        r_arm_cnt;
    logic              w_armed;
    logic              w_fall;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;
    logic              r_samp [0:1];
    logic              w_majority;
    logic              w_decide;
    logic              w_bit_end;

    rx_state_t          r_state;
    rx_state_t          w_state_next;
    logic [SAMP_W-1:0]  r_sample_cnt;
    logic [SAMP_W-1:0]  w_sample_next;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [BIT_W-1:0]   w_bit_next;
    logic               r_stop_cnt;
    logic               w_stop_next;
    logic [DATA_SIZE-1:0] r_shift;
    logic [DATA_SIZE-1:0] w_shift_next;
    logic               r_perr;
    logic               w_perr_next;
    logic               r_ferr;
    logic               w_ferr_next;
    logic               w_frame_ferr;
    logic               w_push;

    logic [ENTRY_W-1:0]                  w_push_data;
    logic [ENTRY_W-1:0]                  w_fifo_rdata;
    logic                                w_fifo_full;
    logic                                w_fifo_empty;
    logic                                w_pop_ok;
    logic [$clog2(FIFO_DEPTH+1)-1:0]     w_fifo_count;
    logic                                r_overrun;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
            r_arm_cnt <= '0;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + 2'd1;
            end
        end
    end

    // Edge detection waits until the chain holds real line samples, so a line
    // that is low when reset releases is not mistaken for a start bit.
    assign w_armed = (r_arm_cnt == 2'd3);
    assign w_fall  = w_armed && r_rx_prev && !r_rx_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
        end
    end

    assign w_tick    = (r_tick_cnt == TICK_W'(BAUD_DV - 1));
    assign w_decide  = w_tick && (r_sample_cnt == SAMP_W'(SAMPLE/2 + 1));
    assign w_bit_end = w_tick && (r_sample_cnt == SAMP_W'(SAMPLE - 1));

    // First two votes are stored; the third is the live sample at the decide tick.
    for (genvar gi = 0; gi < 2; gi++) begin : g_samp
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_samp[gi] <= 1'b1;
            end else if (w_tick && (r_sample_cnt == SAMP_W'(SAMPLE/2 - 1 + gi))) begin
                r_samp[gi] <= r_rx_sync;
            end
        end
    end

    assign w_majority   = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rx_sync) | (r_samp[1] & r_rx_sync);
    assign w_frame_ferr = r_ferr | ~w_majority;
    assign w_push_data  = {w_frame_ferr, r_perr, r_shift};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_sample_cnt <= w_sample_next;
            r_bit_cnt    <= w_bit_next;
            r_stop_cnt   <= w_stop_next;
            r_shift      <= w_shift_next;
            r_perr       <= w_perr_next;
            r_ferr       <= w_ferr_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_sample_next = r_sample_cnt;
        w_bit_next    = r_bit_cnt;
        w_stop_next   = r_stop_cnt;
        w_shift_next  = r_shift;
        w_perr_next   = r_perr;
        w_ferr_next   = r_ferr;
        w_push        = 1'b0;

        if (w_tick && (r_state != ST_IDLE) && (r_state != ST_BREAK)) begin
            w_sample_next = w_bit_end ? '0 : r_sample_cnt + SAMP_W'(1);
        end

        unique case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_next  = ST_START;
                    w_sample_next = '0;
                    w_bit_next    = '0;
                    w_stop_next   = 1'b0;
                    w_perr_next   = 1'b0;
                    w_ferr_next   = 1'b0;
                end
            end
            ST_START: begin
                if (w_decide && w_majority) begin
                    w_state_next = ST_IDLE;
                end else if (w_bit_end) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_decide) begin
                    w_shift_next = {w_majority, r_shift[DATA_SIZE-1:1]};
                end
                if (w_bit_end) begin
                    if (r_bit_cnt == BIT_W'(DATA_SIZE - 1)) begin
                        w_state_next = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_next = r_bit_cnt + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (w_decide) begin
                    w_perr_next = ((^r_shift) ^ w_majority) != PAR_TARGET;
                end
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // The last stop bit pushes at its mid sample, not at bit end.
                if (w_decide) begin
                    w_ferr_next = w_frame_ferr;
                    if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                        w_push       = 1'b1;
                        w_state_next = w_majority ? ST_IDLE : ST_BREAK;
                    end
                end
                if (w_bit_end) begin
                    w_stop_next = 1'b1;
                end
            end
            ST_BREAK: begin
                if (r_rx_sync) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_pop_ok = recv_ack && !w_fifo_empty;

    uart_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        .i_pop   (recv_ack),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_push && w_fifo_full && !w_pop_ok) begin
            r_overrun <= 1'b1;
        end else if (w_pop_ok) begin
            r_overrun <= 1'b0;
        end
    end

    assign {frame_err, parity_err, dout} = w_fifo_rdata;
    assign recv_req   = !w_fifo_empty;
    assign overrun    = r_overrun;
    assign fifo_count = w_fifo_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized frames into an 8N1 and an 8E1 receiver, checked
// against queue-based models of the expected FIFO contents and overrun flag.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int BIT_CLKS = 160;
    localparam int DEPTH    = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_n, rx_e, ack_n, ack_e;
    logic [7:0] dout_n, dout_e;
    logic       perr_n, ferr_n, req_n, ovr_n;
    logic       perr_e, ferr_e, req_e, ovr_e;
    logic [2:0] cnt_n, cnt_e;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] q_n [$];
    logic [9:0] q_e [$];
    logic       ovr_n_model = 1'b0;
    logic       ovr_e_model = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .SYS_FREQ(1600000), .BAUD_RATE(10000), .SAMPLE(16), .DATA_SIZE(8),
        .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .rx(rx_n), .dout(dout_n),
        .parity_err(perr_n), .frame_err(ferr_n), .recv_req(req_n),
        .recv_ack(ack_n), .overrun(ovr_n), .fifo_count(cnt_n)
    );

    uart_rx_fifo #(
        .SYS_FREQ(1600000), .BAUD_RATE(10000), .SAMPLE(16), .DATA_SIZE(8),
        .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) u_dut_par (
        .clk(clk), .reset_n(reset_n), .rx(rx_e), .dout(dout_e),
        .parity_err(perr_e), .frame_err(ferr_e), .recv_req(req_e),
        .recv_ack(ack_e), .overrun(ovr_e), .fifo_count(cnt_e)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input bit which, input logic v, input int clks);
        if (which) rx_e = v; else rx_n = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input bit which, input logic [7:0] data, input bit has_par,
                              input logic par, input logic stop);
        $display("[%0t] frame on %s: data=0x%02h par=%0b stop=%0b", $time, which ? "8E1" : "8N1", data, par, stop);
        drive_bit(which, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(which, data[i], BIT_CLKS);
        if (has_par) drive_bit(which, par, BIT_CLKS);
        drive_bit(which, stop, BIT_CLKS);
    endtask

    // Expected receive behaviour: entries queue up to DEPTH, extras are lost and flagged.
    task automatic model_push(input bit which, input logic [9:0] e);
        if (which) begin
            if (q_e.size() < DEPTH) q_e.push_back(e); else ovr_e_model = 1'b1;
        end else begin
            if (q_n.size() < DEPTH) q_n.push_back(e); else ovr_n_model = 1'b1;
        end
    endtask

    task automatic pulse_ack(input bit which);
        logic [9:0] dummy;
        if (which) ack_e = 1'b1; else ack_n = 1'b1;
        @(negedge clk);
        ack_e = 1'b0;
        ack_n = 1'b0;
        if (which) begin
            if (q_e.size() != 0) begin dummy = q_e.pop_front(); ovr_e_model = 1'b0; end
        end else begin
            if (q_n.size() != 0) begin dummy = q_n.pop_front(); ovr_n_model = 1'b0; end
        end
        $display("[%0t] ack on %s", $time, which ? "8E1" : "8N1");
        @(negedge clk);
    endtask

    task automatic check_n(input string tag);
        logic [9:0] h;
        h = (q_n.size() != 0) ? q_n[0] : 10'd0;
        check({tag, ".n.req"},   32'(req_n),  32'(q_n.size() != 0));
        check({tag, ".n.count"}, 32'(cnt_n),  32'(q_n.size()));
        check({tag, ".n.dout"},  32'(dout_n), 32'(h[7:0]));
        check({tag, ".n.perr"},  32'(perr_n), 32'(h[8]));
        check({tag, ".n.ferr"},  32'(ferr_n), 32'(h[9]));
        check({tag, ".n.ovr"},   32'(ovr_n),  32'(ovr_n_model));
    endtask

    task automatic check_e(input string tag);
        logic [9:0] h;
        h = (q_e.size() != 0) ? q_e[0] : 10'd0;
        check({tag, ".e.req"},   32'(req_e),  32'(q_e.size() != 0));
        check({tag, ".e.count"}, 32'(cnt_e),  32'(q_e.size()));
        check({tag, ".e.dout"},  32'(dout_e), 32'(h[7:0]));
        check({tag, ".e.perr"},  32'(perr_e), 32'(h[8]));
        check({tag, ".e.ferr"},  32'(ferr_e), 32'(h[9]));
        check({tag, ".e.ovr"},   32'(ovr_e),  32'(ovr_e_model));
    endtask

    initial begin
        logic [7:0] d_n, d_e, bad;
        logic       p_e;

        reset_n = 1'b1;
        rx_n    = 1'b1;
        rx_e    = 1'b1;
        ack_n   = 1'b0;
        ack_e   = 1'b0;
        #2 reset_n = 1'b0;
        repeat (5) @(negedge clk);
        check_n("reset");
        check_e("reset");
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        // 8N1 0xA5
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        model_push(1'b0, {1'b0, 1'b0, 8'hA5});
        repeat (10) @(negedge clk);
        check_n("a5");
        pulse_ack(1'b0);
        check_n("a5_ack");

        // 8E1 0x03: parity 1 is wrong for even parity, parity 0 is right
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        model_push(1'b1, {1'b0, 1'b1, 8'h03});
        repeat (10) @(negedge clk);
        check_e("par_bad");
        pulse_ack(1'b1);
        send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
        model_push(1'b1, {1'b0, 1'b0, 8'h03});
        repeat (10) @(negedge clk);
        check_e("par_ok");
        pulse_ack(1'b1);

        // Stop bit 0 followed by a long break: exactly one errored entry
        bad = 8'($urandom_range(0, 255));
        send_frame(1'b0, bad, 1'b0, 1'b0, 1'b0);
        model_push(1'b0, {1'b1, 1'b0, bad});
        drive_bit(1'b0, 1'b0, 3 * BIT_CLKS);
        check_n("break_low");
        drive_bit(1'b0, 1'b1, 2 * BIT_CLKS);
        check_n("break_high");
        pulse_ack(1'b0);
        send_frame(1'b0, 8'h5C, 1'b0, 1'b0, 1'b1);
        model_push(1'b0, {1'b0, 1'b0, 8'h5C});
        repeat (10) @(negedge clk);
        check_n("after_break");
        pulse_ack(1'b0);

        // Five frames without ack into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
            model_push(1'b0, {2'b00, 8'(i)});
        end
        repeat (10) @(negedge clk);
        check_n("overrun");
        pulse_ack(1'b0);
        check_n("overrun_ack");
        for (int i = 0; i < 3; i++) pulse_ack(1'b0);
        check_n("drained");

        // Short low glitch on an idle line
        rx_n = 1'b0;
        repeat (4) @(negedge clk);
        rx_n = 1'b1;
        repeat (300) @(negedge clk);
        check_n("glitch");
        check("glitch.state", 32'(u_dut.r_state), 32'(ST_IDLE));
        send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
        model_push(1'b0, {2'b00, 8'hC3});
        repeat (10) @(negedge clk);
        check_n("post_glitch");

        // Reset in the last data bit (low) of 0x5A, then 0x3C
        d_n = 8'h5A;
        drive_bit(1'b0, 1'b0, BIT_CLKS);
        for (int i = 0; i < 7; i++) drive_bit(1'b0, d_n[i], BIT_CLKS);
        drive_bit(1'b0, d_n[7], 80);
        reset_n = 1'b0;
        q_n.delete();
        q_e.delete();
        ovr_n_model = 1'b0;
        ovr_e_model = 1'b0;
        repeat (3) @(negedge clk);
        check_n("rst_mid");
        check_e("rst_mid");
        reset_n = 1'b1;
        drive_bit(1'b0, d_n[7], 77);
        drive_bit(1'b0, 1'b1, BIT_CLKS + 50);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        model_push(1'b0, {2'b00, 8'h3C});
        repeat (10) @(negedge clk);
        check_n("rst_3c");
        pulse_ack(1'b0);

        // Random traffic on both receivers, acks at random
        for (int it = 0; it < 10; it++) begin
            d_n = 8'($urandom_range(0, 255));
            d_e = 8'($urandom_range(0, 255));
            p_e = 1'($urandom_range(0, 1));
            fork
                send_frame(1'b0, d_n, 1'b0, 1'b0, 1'b1);
                send_frame(1'b1, d_e, 1'b1, p_e, 1'b1);
            join
            model_push(1'b0, {2'b00, d_n});
            model_push(1'b1, {1'b0, p_e ^ (^d_e), d_e});
            repeat (10) @(negedge clk);
            check_n("rand");
            check_e("rand");
            if ($urandom_range(0, 2) != 0) pulse_ack(1'b0);
            if ($urandom_range(0, 2) != 0) pulse_ack(1'b1);
        end
        check_n("rand_end");
        check_e("rand_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
